// File: rtl/key_sw_io_pkg.sv
// Shared constants for the KEY/SW memory-mapped input block:
// register addresses, control-register bit positions and the window base.
package key_sw_io_pkg;

  localparam logic [15:0] WIN_BASE   = 16'hFFF0;
  localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
  localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
  localparam logic [15:0] ADDR_SCTRL = 16'hFFF6;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 8;

  // Word index inside the window, taken from ADDR[2:1].
  typedef enum logic [1:0] {
    REG_KDATA = ADDR_KDATA[2:1],
    REG_SDATA = ADDR_SDATA[2:1],
    REG_KCTRL = ADDR_KCTRL[2:1],
    REG_SCTRL = ADDR_SCTRL[2:1]
  } reg_sel_e;

  function automatic logic [15:0] ctrl_word(input logic ready, input logic ovr, input logic ie);
    logic [15:0] w;
    w = '0;
    w[CTRL_READY] = ready;
    w[CTRL_OVR]   = ovr;
    w[CTRL_IE]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer, stability counter and committed register for one
// group of inputs. evt is high on the edge where the committed value loads
// a new (different) value.
module io_debounce
  import key_sw_io_pkg::*;
#(
  parameter int W        = 4,
  parameter int DEBOUNCE = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         evt
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [CW-1:0] cnt;

  // sync2 has held its value for DEBOUNCE cycles and differs from q
  assign evt = (cnt == CNT_MAX) && (sync2 != q);

  // synchronize, count stable cycles (restart on any change), commit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt   <= '0;
      q     <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (evt) begin
        q <= sync2;
      end
    end
  end

endmodule

// File: rtl/key_sw_io.sv
// Memory-mapped KEY/SW input responder at 0xFFF0-0xFFF7.
// Optional interrupt enable/output controlled by macro KEY_SW_IO_IRQ_EN.
module key_sw_io
  import key_sw_io_pkg::*;
#(
  parameter int DBITS    = 16,
  parameter int DEBOUNCE = 100000,
  parameter int NKEYS    = 4,
  parameter int NSW      = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ADDR,
  input  logic             RE,
  input  logic             WE,
  input  logic [DBITS-1:0] DIN,
  output logic [DBITS-1:0] DOUT,
  output logic             SEL,
  input  logic [NKEYS-1:0] KEY_N,
  input  logic [NSW-1:0]   SW,
  output logic             IRQ
);

  localparam logic [DBITS-4:0] WIN_TAG = (DBITS-3)'(WIN_BASE >> 3);

  logic [NKEYS-1:0] key_q;
  logic             key_evt;
  logic [NSW-1:0]   sw_q;
  logic             sw_evt;

  logic k_ready, k_ovr, k_ie;
  logic s_ready, s_ovr, s_ie;

  reg_sel_e reg_idx;
  logic     rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;
  logic     unused_bits;

  io_debounce #(.W(NKEYS), .DEBOUNCE(DEBOUNCE)) u_key_db (
    .clk (CLK),
    .rst (RESET),
    .din (~KEY_N),
    .q   (key_q),
    .evt (key_evt)
  );

  io_debounce #(.W(NSW), .DEBOUNCE(DEBOUNCE)) u_sw_db (
    .clk (CLK),
    .rst (RESET),
    .din (SW),
    .q   (sw_q),
    .evt (sw_evt)
  );

  assign reg_idx  = reg_sel_e'(ADDR[2:1]);
  assign SEL      = (ADDR[DBITS-1:3] == WIN_TAG);
  assign rd_kdata = RE & SEL & (reg_idx == REG_KDATA);
  assign rd_sdata = RE & SEL & (reg_idx == REG_SDATA);
  assign wr_kctrl = WE & SEL & (reg_idx == REG_KCTRL);
  assign wr_sctrl = WE & SEL & (reg_idx == REG_SCTRL);

  // DIN carries only the Overrun/IE bits we care about; ADDR[0] is a byte lane
  assign unused_bits = ^{DIN, ADDR[0]};

  // Ready/Overrun for both groups; a DATA read on the event edge
  // consumes the old value, so it neither clears Ready nor flags overrun
  always_ff @(posedge CLK) begin
    if (RESET) begin
      k_ready <= 1'b0;
      k_ovr   <= 1'b0;
      s_ready <= 1'b0;
      s_ovr   <= 1'b0;
    end else begin
      if (key_evt) begin
        k_ready <= 1'b1;
      end else if (rd_kdata) begin
        k_ready <= 1'b0;
      end
      if (key_evt && k_ready && !rd_kdata) begin
        k_ovr <= 1'b1;
      end else if (wr_kctrl && !DIN[CTRL_OVR]) begin
        k_ovr <= 1'b0;
      end

      if (sw_evt) begin
        s_ready <= 1'b1;
      end else if (rd_sdata) begin
        s_ready <= 1'b0;
      end
      if (sw_evt && s_ready && !rd_sdata) begin
        s_ovr <= 1'b1;
      end else if (wr_sctrl && !DIN[CTRL_OVR]) begin
        s_ovr <= 1'b0;
      end
    end
  end

`ifdef KEY_SW_IO_IRQ_EN
  logic irq_q;

  // interrupt enables written from DIN[8] on CTRL stores
  always_ff @(posedge CLK) begin
    if (RESET) begin
      k_ie <= 1'b0;
      s_ie <= 1'b0;
    end else begin
      if (wr_kctrl) k_ie <= DIN[CTRL_IE];
      if (wr_sctrl) s_ie <= DIN[CTRL_IE];
    end
  end

  // registered interrupt request, one cycle behind Ready&IE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (k_ready & k_ie) | (s_ready & s_ie);
    end
  end

  assign IRQ = irq_q;
`else
  assign k_ie = 1'b0;
  assign s_ie = 1'b0;
  assign IRQ  = 1'b0;
`endif

  // zero-latency read mux; zero outside the window
  always_comb begin
    DOUT = '0;
    if (SEL) begin
      case (reg_idx)
        REG_KDATA: DOUT = DBITS'(key_q);
        REG_SDATA: DOUT = DBITS'(sw_q);
        REG_KCTRL: DOUT = DBITS'(ctrl_word(k_ready, k_ovr, k_ie));
        REG_SCTRL: DOUT = DBITS'(ctrl_word(s_ready, s_ovr, s_ie));
        default:   DOUT = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sw_io.sv
// Self-checking bench for key_sw_io with DEBOUNCE=4.
module tb_key_sw_io;

  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] ADDR;
  logic        RE, WE;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        SEL;
  logic [3:0]  KEY_N;
  logic [9:0]  SW;
  logic        IRQ;

  int tests = 0;
  int fails = 0;

  key_sw_io #(.DBITS(16), .DEBOUNCE(D), .NKEYS(4), .NSW(10)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .RE(RE), .WE(WE), .DIN(DIN),
    .DOUT(DOUT), .SEL(SEL), .KEY_N(KEY_N), .SW(SW), .IRQ(IRQ)
  );

  always #10 CLK = ~CLK;

  // ---------------- reference model ----------------
  // A value commits one edge after it has been the raw sample for D+1
  // consecutive edges, counted two edges back (two-stage synchronizer).
  logic [3:0] m_kh [0:D+1];
  logic [9:0] m_sh [0:D+1];
  logic [3:0] m_kq = '0;
  logic [9:0] m_sq = '0;
  logic m_kr = 0, m_ko = 0, m_kie = 0;
  logic m_sr = 0, m_so = 0, m_sie = 0;
  logic m_irq = 0;

  initial begin
    for (int i = 0; i <= D+1; i++) begin
      m_kh[i] = '0;
      m_sh[i] = '0;
    end
  end

  function automatic logic m_hit(input logic [15:0] a);
    return a[15:3] == 13'h1FFE;
  endfunction

  function automatic logic [15:0] m_dout(input logic [15:0] a);
    if (!m_hit(a)) return 16'h0000;
    case (a[2:1])
      2'd0: return {12'h000, m_kq};
      2'd1: return {6'h00, m_sq};
      2'd2: return {7'h00, m_kie, 5'h00, m_ko, 1'b0, m_kr};
      default: return {7'h00, m_sie, 5'h00, m_so, 1'b0, m_sr};
    endcase
  endfunction

  always @(posedge CLK) begin : model
    logic kevt, sevt, rd_k, rd_s, wr_k, wr_s, k_set, s_set;
    if (RESET) begin
      for (int i = 0; i <= D+1; i++) begin
        m_kh[i] = '0;
        m_sh[i] = '0;
      end
      m_kq = '0; m_sq = '0;
      m_kr = 0; m_ko = 0; m_kie = 0;
      m_sr = 0; m_so = 0; m_sie = 0;
      m_irq = 0;
    end else begin
      kevt = 1'b1;
      sevt = 1'b1;
      for (int i = 2; i <= D+1; i++) begin
        if (m_kh[i] != m_kh[1]) kevt = 1'b0;
        if (m_sh[i] != m_sh[1]) sevt = 1'b0;
      end
      if (m_kh[1] == m_kq) kevt = 1'b0;
      if (m_sh[1] == m_sq) sevt = 1'b0;
      rd_k = RE && m_hit(ADDR) && ADDR[2:1] == 2'd0;
      rd_s = RE && m_hit(ADDR) && ADDR[2:1] == 2'd1;
      wr_k = WE && m_hit(ADDR) && ADDR[2:1] == 2'd2;
      wr_s = WE && m_hit(ADDR) && ADDR[2:1] == 2'd3;
`ifdef KEY_SW_IO_IRQ_EN
      m_irq = (m_kr & m_kie) | (m_sr & m_sie);
      if (wr_k) m_kie = DIN[8];
      if (wr_s) m_sie = DIN[8];
`endif
      k_set = kevt && m_kr && !rd_k;
      s_set = sevt && m_sr && !rd_s;
      if (k_set) m_ko = 1; else if (wr_k && !DIN[2]) m_ko = 0;
      if (s_set) m_so = 1; else if (wr_s && !DIN[2]) m_so = 0;
      if (kevt) begin m_kr = 1; m_kq = m_kh[1]; end else if (rd_k) m_kr = 0;
      if (sevt) begin m_sr = 1; m_sq = m_sh[1]; end else if (rd_s) m_sr = 0;
      for (int i = D+1; i > 0; i--) begin
        m_kh[i] = m_kh[i-1];
        m_sh[i] = m_sh[i-1];
      end
      m_kh[0] = ~KEY_N;
      m_sh[0] = SW;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic idle();
    ADDR = 16'h0000; RE = 0; WE = 0; DIN = 16'h0000;
  endtask

  task automatic peek(input logic [15:0] a, input logic [15:0] exp, input string nm);
    ADDR = a; RE = 0; WE = 0;
    #1;
    check(nm, {16'h0, DOUT}, {16'h0, exp});
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; WE = 1; RE = 0; DIN = d;
    tick();
    idle();
  endtask

  task automatic load(input logic [15:0] a);
    ADDR = a; RE = 1; WE = 0;
    tick();
    idle();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        sel;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{16'hFFF0, 1'b1, 16'h0000};
    vecs[1] = '{16'hFFF1, 1'b1, 16'h0000};
    vecs[2] = '{16'hFFF2, 1'b1, 16'h0000};
    vecs[3] = '{16'hFFF4, 1'b1, 16'h0000};
    vecs[4] = '{16'hFFF6, 1'b1, 16'h0000};
    vecs[5] = '{16'hFFF7, 1'b1, 16'h0000};
    vecs[6] = '{16'hFFF8, 1'b0, 16'h0000};
    vecs[7] = '{16'hFFEF, 1'b0, 16'h0000};
    vecs[8] = '{16'hFFFC, 1'b0, 16'h0000};
    vecs[9] = '{16'h0000, 1'b0, 16'h0000};

    RESET = 1; KEY_N = 4'hF; SW = '0;
    idle();
    tick(2);
    RESET = 0;
    tick(20);

    // reset state and address window
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      ADDR = vecs[i].addr;
      #1;
      check($sformatf("sel_%h", vecs[i].addr), {31'h0, SEL}, {31'h0, vecs[i].sel});
      check($sformatf("dout_%h", vecs[i].addr), {16'h0, DOUT}, {16'h0, vecs[i].dout});
    end
    check("irq_reset", {31'h0, IRQ}, 32'h0);
    idle();

    // KEY0 press: commits exactly 7 edges later
    KEY_N = 4'b1110;
    tick(6);
    peek(16'hFFF0, 16'h0000, "kdata_early");
    tick();
    peek(16'hFFF0, 16'h0001, "kdata_commit");
    peek(16'hFFF4, 16'h0001, "kctrl_ready");
    load(16'hFFF0);
    peek(16'hFFF4, 16'h0000, "kctrl_after_read");

    // 3-cycle switch glitch never commits
    SW = 10'h3FF;
    tick(3);
    SW = 10'h000;
    tick(12);
    peek(16'hFFF2, 16'h0000, "sdata_glitch");
    peek(16'hFFF6, 16'h0000, "sctrl_glitch");

    // two commits without a read -> overrun, then cleared by store
    SW = 10'h155;
    tick(8);
    peek(16'hFFF2, 16'h0155, "sdata_155");
    SW = 10'h2AA;
    tick(8);
    peek(16'hFFF2, 16'h02AA, "sdata_2aa");
    peek(16'hFFF6, 16'h0005, "sctrl_ovr");
    store(16'hFFF6, 16'h0004);
    peek(16'hFFF6, 16'h0005, "sctrl_store1_ignored");
    store(16'hFFF6, 16'h0000);
    peek(16'hFFF6, 16'h0001, "sctrl_ovr_clr");
    store(16'hFFF2, 16'hFFFF);
    peek(16'hFFF2, 16'h02AA, "sdata_store_ignored");

    // key release commit on the same edge as a KDATA read
    KEY_N = 4'b1111;
    tick(6);
    ADDR = 16'hFFF0; RE = 1;
    #1;
    check("kdata_precommit", {16'h0, DOUT}, 32'h0001);
    tick();
    idle();
    peek(16'hFFF4, 16'h0001, "kctrl_evt_wins");
    peek(16'hFFF0, 16'h0000, "kdata_released");
    load(16'hFFF0);

`ifdef KEY_SW_IO_IRQ_EN
    store(16'hFFF4, 16'h0100);
    peek(16'hFFF4, 16'h0100, "kctrl_ie");
    KEY_N = 4'b1101;
    tick(7);
    peek(16'hFFF4, 16'h0101, "kctrl_ie_ready");
    check("irq_lag", {31'h0, IRQ}, 32'h0);
    tick();
    check("irq_rise", {31'h0, IRQ}, 32'h1);
    load(16'hFFF0);
    check("irq_hold", {31'h0, IRQ}, 32'h1);
    tick();
    check("irq_fall", {31'h0, IRQ}, 32'h0);
`else
    store(16'hFFF4, 16'h0100);
    peek(16'hFFF4, 16'h0000, "kctrl_no_ie");
    KEY_N = 4'b1101;
    tick(9);
    peek(16'hFFF4, 16'h0001, "kctrl_ready_no_ie");
    check("irq_tied", {31'h0, IRQ}, 32'h0);
    load(16'hFFF0);
`endif
    peek(16'hFFF0, 16'h0002, "kdata_key1");

    // randomized traffic against the model, with occasional resets
    RESET = 1;
    tick();
    RESET = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) KEY_N = 4'($urandom);
      if ($urandom_range(0, 9) == 0) SW = 10'($urandom);
      RESET = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) ADDR = 16'($urandom);
      else ADDR = 16'hFFF0 | 16'($urandom_range(0, 7));
      RE  = ($urandom_range(0, 3) == 0);
      WE  = ($urandom_range(0, 5) == 0);
      DIN = 16'($urandom);
      #1;
      check("rand", {14'h0, SEL, IRQ, DOUT}, {14'h0, m_hit(ADDR), m_irq, m_dout(ADDR)});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
